// File: rtl/saturn_bus_cfg_seq_pkg.sv
// Shared definitions for the Saturn bus configuration sequencer: command codes,
// FSM state encoding and address geometry.
package saturn_bus_cfg_seq_pkg;

    localparam int ADDR_W  = 20;
    localparam int NIB_CNT = 5;

    localparam logic [2:0] CMD_NOP    = 3'd0;
    localparam logic [2:0] CMD_CONFIG = 3'd1;
    localparam logic [2:0] CMD_UNCNFG = 3'd2;
    localparam logic [2:0] CMD_RESET  = 3'd3;
    localparam logic [2:0] CMD_C_ID   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_APPLY   = 3'd2,
        ST_IDOUT   = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    // Address as seen through a device's decode mask.
    function automatic logic [ADDR_W-1:0] masked_addr(input logic [ADDR_W-1:0] addr,
                                                      input logic [ADDR_W-1:0] mask);
        return addr & mask;
    endfunction

endpackage

// File: rtl/saturn_bus_cfg_seq_slot.sv
// Per-device configuration slot: holds base, mask, configured and the
// half-configured flag used by devices that take a size then an address.
module saturn_bus_cfg_seq_slot
    import saturn_bus_cfg_seq_pkg::*;
#(
    parameter bit                TWO_STEP   = 1'b0,
    parameter logic [ADDR_W-1:0] RESET_MASK = '0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              cfg,
    input  logic              uncfg,
    input  logic              clr,
    input  logic [ADDR_W-1:0] addr,
    output logic              configured,
    output logic [ADDR_W-1:0] base,
    output logic [ADDR_W-1:0] mask
);

    logic half;

    always_ff @(posedge i_clk) begin
        if (i_reset || clr) begin
            configured <= 1'b0;
            half       <= 1'b0;
            mask       <= RESET_MASK;
            if (i_reset) begin
                base <= '0;
            end
        end else if (cfg) begin
            // A two-step device first learns its size (as a mask), then its address.
            if (!TWO_STEP || half) begin
                base       <= masked_addr(addr, mask);
                configured <= 1'b1;
                half       <= 1'b0;
            end else begin
                mask <= addr;
                half <= 1'b1;
            end
        end else if (uncfg) begin
            configured <= 1'b0;
            half       <= 1'b0;
            if (TWO_STEP) begin
                mask <= '0;
            end
        end
    end

endmodule

// File: rtl/saturn_bus_cfg_seq.sv
// Saturn bus configuration sequencer: runs CONFIG/UNCNFG/RESET/C=ID commands and
// owns per-device base/mask/configured state plus the configuration daisy chain.
module saturn_bus_cfg_seq
    import saturn_bus_cfg_seq_pkg::*;
#(
    parameter int                       N_DEV      = 3,
    parameter logic [N_DEV-1:0]         TWO_STEP   = 3'b110,
    parameter logic [N_DEV*ADDR_W-1:0]  FIXED_MASK = 60'hFFFC0_FFFC0_FFFC0,
    parameter logic [N_DEV*ADDR_W-1:0]  DEV_ID     = 60'h00003_00002_00001
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_clk_en,
    input  logic                      i_cmd_valid,
    input  logic [2:0]                i_cmd,
    output logic                      o_cmd_ready,
    input  logic                      i_nibble_valid,
    input  logic [3:0]                i_nibble,
    output logic                      o_nibble_valid,
    output logic [3:0]                o_nibble,
    output logic                      o_done,
    output logic [N_DEV-1:0]          o_dev_configured,
    output logic [N_DEV*ADDR_W-1:0]   o_dev_base,
    output logic [N_DEV*ADDR_W-1:0]   o_dev_mask,
    output logic [N_DEV-1:0]          o_daisy,
    output logic [2:0]                o_fsm_state
);

    localparam logic [2:0] NIB_LAST = 3'(NIB_CNT - 1);

    state_e            state, state_next;
    logic [ADDR_W-1:0] addr_sr;
    logic [ADDR_W-1:0] id_sr;
    logic [2:0]        nib_cnt;
    logic              op_config;

    logic              accept;
    logic              cfg_go, uncfg_go, clr_go;
    logic [N_DEV-1:0]  uncfg_match;
    logic [N_DEV-1:0]  cfg_sel, uncfg_sel;
    logic              cfg_found, uncfg_found;
    logic [ADDR_W-1:0] cid_value;

    // Handshake: a command is taken on a beat (i_clk_en high) where both
    // i_cmd_valid and o_cmd_ready are high; o_cmd_ready is high only in IDLE and the
    // requester holds i_cmd_valid and i_cmd stable until that beat.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        cfg_go     = 1'b0;
        uncfg_go   = 1'b0;
        clr_go     = 1'b0;
        if (i_clk_en) begin
            unique case (state)
                ST_IDLE: begin
                    if (i_cmd_valid) begin
                        accept = 1'b1;
                        case (i_cmd)
                            CMD_CONFIG, CMD_UNCNFG: state_next = ST_COLLECT;
                            CMD_C_ID:               state_next = ST_IDOUT;
                            CMD_RESET: begin
                                clr_go     = 1'b1;
                                state_next = ST_DONE;
                            end
                            default:                state_next = ST_DONE;
                        endcase
                    end
                end
                ST_COLLECT: begin
                    if (i_nibble_valid && nib_cnt == NIB_LAST) begin
                        state_next = ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    cfg_go     = op_config;
                    uncfg_go   = !op_config;
                    state_next = ST_DONE;
                end
                ST_IDOUT: begin
                    if (nib_cnt == NIB_LAST) begin
                        state_next = ST_DONE;
                    end
                end
                ST_DONE:  state_next = ST_IDLE;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            addr_sr   <= '0;
            id_sr     <= '0;
            nib_cnt   <= '0;
            op_config <= 1'b0;
        end else if (i_clk_en) begin
            if (accept) begin
                addr_sr   <= '0;
                nib_cnt   <= '0;
                op_config <= (i_cmd == CMD_CONFIG);
                id_sr     <= cid_value;
            end else if (state == ST_COLLECT && i_nibble_valid) begin
                addr_sr[{nib_cnt, 2'b00} +: 4] <= i_nibble;
                nib_cnt                         <= nib_cnt + 3'd1;
            end else if (state == ST_IDOUT) begin
                id_sr   <= {4'h0, id_sr[ADDR_W-1:4]};
                nib_cnt <= nib_cnt + 3'd1;
            end
        end
    end

    // Lowest-index priority for both CONFIG target and UNCNFG match; the C=ID
    // value follows the same device the next CONFIG would hit.
    always_comb begin
        cfg_sel     = '0;
        uncfg_sel   = '0;
        cfg_found   = 1'b0;
        uncfg_found = 1'b0;
        cid_value   = '0;
        for (int i = 0; i < N_DEV; i++) begin
            if (!cfg_found && !o_dev_configured[i]) begin
                cfg_sel[i] = 1'b1;
                cfg_found  = 1'b1;
                cid_value  = DEV_ID[i*ADDR_W +: ADDR_W];
            end
            if (!uncfg_found && uncfg_match[i]) begin
                uncfg_sel[i] = 1'b1;
                uncfg_found  = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < N_DEV; g++) begin : g_slot
        localparam logic [ADDR_W-1:0] RESET_MASK =
            TWO_STEP[g] ? '0 : FIXED_MASK[g*ADDR_W +: ADDR_W];

        assign uncfg_match[g] = o_dev_configured[g] &&
            (masked_addr(addr_sr, o_dev_mask[g*ADDR_W +: ADDR_W]) == o_dev_base[g*ADDR_W +: ADDR_W]);

        saturn_bus_cfg_seq_slot #(
            .TWO_STEP   (TWO_STEP[g]),
            .RESET_MASK (RESET_MASK)
        ) u_slot (
            .i_clk      (i_clk),
            .i_reset    (i_reset),
            .cfg        (cfg_go && cfg_sel[g]),
            .uncfg      (uncfg_go && uncfg_sel[g]),
            .clr        (clr_go),
            .addr       (addr_sr),
            .configured (o_dev_configured[g]),
            .base       (o_dev_base[g*ADDR_W +: ADDR_W]),
            .mask       (o_dev_mask[g*ADDR_W +: ADDR_W])
        );

        if (g == 0) begin : g_head
            assign o_daisy[g] = 1'b1;
        end else begin : g_chain
            assign o_daisy[g] = o_daisy[g-1] & o_dev_configured[g-1];
        end
    end

    assign o_cmd_ready    = (state == ST_IDLE);
    assign o_done         = (state == ST_DONE);
    assign o_nibble_valid = (state == ST_IDOUT);
    assign o_nibble       = o_nibble_valid ? id_sr[3:0] : 4'h0;
    assign o_fsm_state    = state;

endmodule

// File: tb/tb_saturn_bus_cfg_seq.sv
// Directed bench for saturn_bus_cfg_seq: a command table with hand-computed device
// state, plus sequences for clock-enable holds and reset mid-command.
module tb_saturn_bus_cfg_seq;

    localparam logic [2:0]  C_NOP = 3'd0, C_CFG = 3'd1, C_UNC = 3'd2, C_RST = 3'd3, C_CID = 3'd4;
    localparam logic [59:0] DEV_IDS = 60'hC0DE2_B0B01_12345;
    localparam logic [59:0] MASK_R  = 60'h00000_00000_FFFC0;
    localparam logic [59:0] MASK_1  = 60'h00000_FC000_FFFC0;
    localparam logic [59:0] MASK_2  = 60'hF0000_FC000_FFFC0;
    localparam logic [59:0] B_0     = 60'h00000_00000_00100;
    localparam logic [59:0] B_01    = 60'h00000_80000_00100;
    localparam logic [59:0] B_012   = 60'hC0000_80000_00100;

    logic        clk = 1'b0;
    logic        rst, clk_en, cmd_valid, nib_valid_in;
    logic [2:0]  cmd;
    logic [3:0]  nib_in;
    logic        cmd_ready, nib_valid_out, done;
    logic [3:0]  nib_out;
    logic [2:0]  dev_cfg, daisy, fsm_state;
    logic [59:0] dev_base, dev_mask;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [2:0]  cmd;
        logic [19:0] addr;
        logic [2:0]  exp_cfg;
        logic [2:0]  exp_daisy;
        logic [59:0] exp_base;
        logic [59:0] exp_mask;
        int          exp_lat;
        logic [19:0] exp_id;
    } vec_t;

    vec_t vecs[19];

    saturn_bus_cfg_seq #(
        .N_DEV      (3),
        .TWO_STEP   (3'b110),
        .FIXED_MASK (60'hFFFC0_FFFC0_FFFC0),
        .DEV_ID     (DEV_IDS)
    ) dut (
        .i_clk            (clk),
        .i_reset          (rst),
        .i_clk_en         (clk_en),
        .i_cmd_valid      (cmd_valid),
        .i_cmd            (cmd),
        .o_cmd_ready      (cmd_ready),
        .i_nibble_valid   (nib_valid_in),
        .i_nibble         (nib_in),
        .o_nibble_valid   (nib_valid_out),
        .o_nibble         (nib_out),
        .o_done           (done),
        .o_dev_configured (dev_cfg),
        .o_dev_base       (dev_base),
        .o_dev_mask       (dev_mask),
        .o_daisy          (daisy),
        .o_fsm_state      (fsm_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Accepts one command and feeds its address nibbles without gaps; returns beats
    // from the accept beat to the done beat and any ID nibbles seen on the way.
    task automatic run_cmd(input logic [2:0] c, input logic [19:0] addr,
                           output int lat, output logic [19:0] id);
        int nib_i = 0;
        int idn   = 0;
        id = '0;
        check("ready_before_accept", {63'd0, cmd_ready}, 64'd1);
        cmd_valid = 1'b1;
        cmd       = c;
        tick();
        cmd_valid = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            if (nib_valid_out && idn < 5) begin
                id[idn*4 +: 4] = nib_out;
                idn++;
            end
            if ((c == C_CFG || c == C_UNC) && nib_i < 5) begin
                nib_valid_in = 1'b1;
                nib_in       = addr[nib_i*4 +: 4];
                nib_i++;
            end else begin
                nib_valid_in = 1'b0;
            end
            tick();
            lat++;
        end
        nib_valid_in = 1'b0;
        check("done_reached", {63'd0, done}, 64'd1);
        tick();
    endtask

    task automatic check_devs(input string tag, input logic [2:0] exp_cfg, input logic [2:0] exp_daisy,
                              input logic [59:0] exp_base, input logic [59:0] exp_mask);
        check({tag, "_cfg"},   {61'd0, dev_cfg}, {61'd0, exp_cfg});
        check({tag, "_daisy"}, {61'd0, daisy},   {61'd0, exp_daisy});
        check({tag, "_mask"},  {4'd0, dev_mask}, {4'd0, exp_mask});
        for (int i = 0; i < 3; i++) begin
            if (exp_cfg[i]) begin
                check($sformatf("%s_base%0d", tag, i), {44'd0, dev_base[i*20 +: 20]},
                      {44'd0, exp_base[i*20 +: 20]});
            end
        end
    endtask

    initial begin
        int          lat;
        logic [19:0] id;
        int          nib_i;
        logic [19:0] addr6;

        vecs[0]  = '{C_CID, 20'h00000, 3'b000, 3'b001, 60'h0,  MASK_R, 6, 20'h12345};
        vecs[1]  = '{C_CFG, 20'h00100, 3'b001, 3'b011, B_0,    MASK_R, 7, 20'h0};
        vecs[2]  = '{C_CFG, 20'hFC000, 3'b001, 3'b011, B_0,    MASK_1, 7, 20'h0};
        vecs[3]  = '{C_CID, 20'h00000, 3'b001, 3'b011, B_0,    MASK_1, 6, 20'hB0B01};
        vecs[4]  = '{C_CFG, 20'h80000, 3'b011, 3'b111, B_01,   MASK_1, 7, 20'h0};
        vecs[5]  = '{C_UNC, 20'h80123, 3'b001, 3'b011, B_0,    MASK_R, 7, 20'h0};
        vecs[6]  = '{C_UNC, 20'h55555, 3'b001, 3'b011, B_0,    MASK_R, 7, 20'h0};
        vecs[7]  = '{C_CFG, 20'hFC000, 3'b001, 3'b011, B_0,    MASK_1, 7, 20'h0};
        vecs[8]  = '{C_CFG, 20'h80000, 3'b011, 3'b111, B_01,   MASK_1, 7, 20'h0};
        vecs[9]  = '{C_CFG, 20'hF0000, 3'b011, 3'b111, B_01,   MASK_2, 7, 20'h0};
        vecs[10] = '{C_CID, 20'h00000, 3'b011, 3'b111, B_01,   MASK_2, 6, 20'hC0DE2};
        vecs[11] = '{C_CFG, 20'hC0000, 3'b111, 3'b111, B_012,  MASK_2, 7, 20'h0};
        vecs[12] = '{C_CID, 20'h00000, 3'b111, 3'b111, B_012,  MASK_2, 6, 20'h00000};
        vecs[13] = '{C_CFG, 20'h12345, 3'b111, 3'b111, B_012,  MASK_2, 7, 20'h0};
        vecs[14] = '{C_NOP, 20'h00000, 3'b111, 3'b111, B_012,  MASK_2, 1, 20'h0};
        vecs[15] = '{3'd5,  20'h00000, 3'b111, 3'b111, B_012,  MASK_2, 1, 20'h0};
        vecs[16] = '{C_RST, 20'h00000, 3'b000, 3'b001, 60'h0,  MASK_R, 1, 20'h0};
        vecs[17] = '{C_CFG, 20'h12345, 3'b001, 3'b011, 60'h12340, MASK_R, 7, 20'h0};
        vecs[18] = '{C_UNC, 20'h12355, 3'b000, 3'b001, 60'h0,  MASK_R, 7, 20'h0};

        rst = 1'b1; clk_en = 1'b1; cmd_valid = 1'b0; cmd = '0;
        nib_valid_in = 1'b0; nib_in = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        check("rst_ready",     {63'd0, cmd_ready},     64'd1);
        check("rst_done",      {63'd0, done},          64'd0);
        check("rst_nib_valid", {63'd0, nib_valid_out}, 64'd0);
        check("rst_nibble",    {60'd0, nib_out},       64'd0);
        check("rst_base",      {4'd0, dev_base},       64'd0);
        check_devs("rst", 3'b000, 3'b001, 60'h0, MASK_R);

        for (int v = 0; v < 19; v++) begin
            run_cmd(vecs[v].cmd, vecs[v].addr, lat, id);
            check($sformatf("v%0d_latency", v), 64'(lat), 64'(vecs[v].exp_lat));
            if (vecs[v].cmd == C_CID) begin
                check($sformatf("v%0d_id", v), {44'd0, id}, {44'd0, vecs[v].exp_id});
            end
            check_devs($sformatf("v%0d", v), vecs[v].exp_cfg, vecs[v].exp_daisy,
                       vecs[v].exp_base, vecs[v].exp_mask);
        end

        // C_ID with clock-enable gaps: nibble and done levels must hold.
        cmd_valid = 1'b1; cmd = C_CID;
        tick();
        cmd_valid = 1'b0;
        check("hold_n0", {59'd0, nib_valid_out, nib_out}, {59'd0, 1'b1, 4'h5});
        tick();
        check("hold_n1", {59'd0, nib_valid_out, nib_out}, {59'd0, 1'b1, 4'h4});
        clk_en = 1'b0;
        repeat (3) tick();
        check("hold_n1_gated", {59'd0, nib_valid_out, nib_out}, {59'd0, 1'b1, 4'h4});
        clk_en = 1'b1;
        tick();
        check("hold_n2", {59'd0, nib_valid_out, nib_out}, {59'd0, 1'b1, 4'h3});
        tick();
        check("hold_n3", {59'd0, nib_valid_out, nib_out}, {59'd0, 1'b1, 4'h2});
        tick();
        check("hold_n4", {59'd0, nib_valid_out, nib_out}, {59'd0, 1'b1, 4'h1});
        tick();
        check("hold_done", {62'd0, done, nib_valid_out}, {62'd0, 1'b1, 1'b0});
        clk_en = 1'b0;
        repeat (2) tick();
        check("hold_done_gated", {63'd0, done}, 64'd1);
        clk_en = 1'b1;
        tick();
        check("hold_done_once", {62'd0, done, cmd_ready}, {62'd0, 1'b0, 1'b1});

        // Configure dev0, then abort a second CONFIG with i_reset after 3 nibbles.
        run_cmd(C_CFG, 20'h00100, lat, id);
        check_devs("pre_abort", 3'b001, 3'b011, B_0, MASK_R);
        addr6 = 20'h00300;
        cmd_valid = 1'b1; cmd = C_CFG;
        tick();
        cmd_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            nib_valid_in = 1'b1;
            nib_in       = addr6[k*4 +: 4];
            tick();
        end
        nib_valid_in = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_ready", {62'd0, cmd_ready, done}, {62'd0, 1'b1, 1'b0});
        check("abort_base",  {4'd0, dev_base}, 64'd0);
        check_devs("abort", 3'b000, 3'b001, 60'h0, MASK_R);

        // New CONFIG with clock-enable and nibble gaps.
        addr6 = 20'h00200;
        cmd_valid = 1'b1; cmd = C_CFG;
        tick();
        cmd_valid = 1'b0;
        nib_i = 0;
        for (int k = 0; k < 60 && !done; k++) begin
            clk_en       = (k % 3 != 2);
            nib_valid_in = (k % 2 == 0) && (nib_i < 5);
            nib_in       = (nib_i < 5) ? addr6[nib_i*4 +: 4] : 4'h0;
            if (clk_en && nib_valid_in) nib_i++;
            tick();
        end
        clk_en = 1'b1;
        nib_valid_in = 1'b0;
        check("gap_done", {63'd0, done}, 64'd1);
        tick();
        check_devs("gap", 3'b001, 3'b011, 60'h00000_00000_00200, MASK_R);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
